// File: rtl/multi_ch_bit_aligner.sv
// Multi-channel bit aligner: per channel, picks rising or falling capture of NTAP taps, manually or via an auto search FSM.
// Optional macro ALIGNER_RELOCK_EN: an edge seen while locked restarts the search instead of raising align_error.
module multi_ch_bit_aligner #(
  parameter int NCH     = 4,
  parameter int NTAP    = 3,
  parameter int DWELL_W = 8,
  parameter int MAX_TRY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto_mode_asyn,
  input  logic [NCH-1:0]      manual_fall_asyn,
  input  logic [NCH*NTAP-1:0] din,
  output logic [NCH*NTAP-1:0] dout,
  output logic [NCH-1:0]      dout_mid,
  output logic [NCH-1:0]      edge_found,
  output logic [NCH-1:0]      latch_edge,
  output logic [NCH-1:0]      align_done,
  output logic [NCH-1:0]      align_error,
  output logic                all_locked
);
  localparam int MID = (NTAP - 1) / 2;
  localparam logic [3:0] TRY_LAST = 4'(MAX_TRY - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = '1;

  typedef enum logic [2:0] {IDLE, SETTLE, WATCH, LOCKED, ERROR} state_t;

  logic                 auto_s1_q, auto_mode_q, auto_prev_q;
  logic [NCH-1:0]       man_s1_q, manual_fall_q;
  logic [NCH-1:0]       pol;
  logic [NCH*NTAP-1:0]  neg_q, dout_q, dout_d;
  logic [NCH-1:0]       edge_q, edge_d;
  logic [NCH-1:0]       le_q, le_d, done_q, done_d, err_q, err_d;
  state_t [NCH-1:0]     state_q, state_d;
  logic [NCH-1:0][DWELL_W-1:0] dwell_q, dwell_d;
  logic [NCH-1:0][3:0]  try_q, try_d;
  logic                 auto_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_s1_q     <= 1'b0;
      auto_mode_q   <= 1'b0;
      auto_prev_q   <= 1'b0;
      man_s1_q      <= '0;
      manual_fall_q <= '0;
    end else begin
      auto_s1_q     <= auto_mode_asyn;
      auto_mode_q   <= auto_s1_q;
      auto_prev_q   <= auto_mode_q;
      man_s1_q      <= manual_fall_asyn;
      manual_fall_q <= man_s1_q;
    end
  end

  assign pol       = auto_mode_q ? le_q : manual_fall_q;
  assign auto_rise = auto_mode_q & ~auto_prev_q;

  // Falling-edge bank only refreshes for channels currently using falling capture.
  always_ff @(negedge clk) begin
    if (rst) begin
      neg_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (pol[c]) neg_q[c*NTAP +: NTAP] <= din[c*NTAP +: NTAP];
      end
    end
  end

  always_comb begin
    dout_d = din;
    edge_d = '0;
    for (int c = 0; c < NCH; c++) begin
      if (pol[c]) dout_d[c*NTAP +: NTAP] = neg_q[c*NTAP +: NTAP];
      for (int t = 0; t < NTAP - 1; t++) begin
        edge_d[c] = edge_d[c] | (dout_q[c*NTAP+t] ^ dout_q[c*NTAP+t+1]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    try_d   = try_q;
    le_d    = le_q;
    done_d  = done_q;
    err_d   = err_q;
    for (int c = 0; c < NCH; c++) begin
      if (!auto_mode_q) begin
        state_d[c] = IDLE;
        done_d[c]  = 1'b0;
        err_d[c]   = 1'b0;
        try_d[c]   = '0;
      end else begin
        case (state_q[c])
          IDLE: begin
            if (auto_rise) begin
              state_d[c] = SETTLE;
              le_d[c]    = 1'b0;
              try_d[c]   = '0;
              dwell_d[c] = '0;
            end
          end
          // The dwell timer doubles as the 2-cycle flush counter here.
          SETTLE: begin
            if (dwell_q[c][0]) begin
              state_d[c] = WATCH;
              dwell_d[c] = '0;
            end else begin
              dwell_d[c] = dwell_q[c] + 1'b1;
            end
          end
          WATCH: begin
            if (edge_q[c]) begin
              if (try_q[c] == TRY_LAST) begin
                state_d[c] = ERROR;
                err_d[c]   = 1'b1;
              end else begin
                state_d[c] = SETTLE;
                le_d[c]    = ~le_q[c];
                try_d[c]   = try_q[c] + 4'd1;
                dwell_d[c] = '0;
              end
            end else if (dwell_q[c] == DWELL_LAST) begin
              state_d[c] = LOCKED;
              done_d[c]  = 1'b1;
            end else begin
              dwell_d[c] = dwell_q[c] + 1'b1;
            end
          end
          LOCKED: begin
            if (edge_q[c]) begin
`ifdef ALIGNER_RELOCK_EN
              state_d[c] = SETTLE;
              done_d[c]  = 1'b0;
              le_d[c]    = ~le_q[c];
              try_d[c]   = '0;
              dwell_d[c] = '0;
`else
              err_d[c]   = 1'b1;
`endif
            end
          end
          ERROR:   err_d[c]   = 1'b1;
          default: state_d[c] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      edge_q  <= '0;
      le_q    <= '0;
      done_q  <= '0;
      err_q   <= '0;
      state_q <= {NCH{IDLE}};
      dwell_q <= '0;
      try_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      edge_q  <= edge_d;
      le_q    <= le_d;
      done_q  <= done_d;
      err_q   <= err_d;
      state_q <= state_d;
      dwell_q <= dwell_d;
      try_q   <= try_d;
    end
  end

  always_comb begin
    dout_mid = '0;
    for (int c = 0; c < NCH; c++) dout_mid[c] = dout_q[c*NTAP+MID];
  end

  assign dout        = dout_q;
  assign edge_found  = edge_q;
  assign latch_edge  = le_q;
  assign align_done  = done_q;
  assign align_error = err_q;
  assign all_locked  = auto_mode_q & (&done_q);
endmodule
